// File: rtl/serial_frame_rx_if.sv
// Serial receive link: one-bit line in, parallel word and status pulses out.
// The master drives the line and observes results; the receiver is the slave.
interface serial_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic              in;
   logic [DATA_W-1:0] data_out;
   logic              valid;
   logic              frame_err;
   logic              busy;

   modport master (output in, input data_out, valid, frame_err, busy);
   modport slave  (input in, output data_out, valid, frame_err, busy);
endinterface

// File: rtl/serial_frame_rx.sv
// Frames an idle-low serial line (start=1, stop=0), deserialises DATA_W bits
// LSB-first with optional even parity, and pulses valid or frame_err per frame.
module serial_frame_rx #(
   parameter int DATA_W    = 8,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_frame_rx_if.slave   bus
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] PAR  = 2'd2;
   localparam logic [1:0] STOP = 2'd3;

   logic [1:0]        state;
   logic [DATA_W-1:0] shreg;
   logic [CW-1:0]     bit_cnt;
   logic              par_ok;

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         shreg         <= '0;
         bit_cnt       <= '0;
         par_ok        <= 1'b1;
         bus.data_out  <= '0;
         bus.valid     <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.valid     <= 1'b0;
         bus.frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  // stays 1 when there is no parity stage to clear it
                  par_ok  <= 1'b1;
               end
            end
            DATA: begin
               shreg   <= {bus.in, shreg[DATA_W-1:1]};
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == LAST)
                  state <= PARITY_EN ? PAR : STOP;
            end
            PAR: begin
               par_ok <= ~((^shreg) ^ bus.in);
               state  <= STOP;
            end
            default: begin
               // a high stop bit is an error, never a new start
               if (!bus.in && par_ok) begin
                  bus.data_out <= shreg;
                  bus.valid    <= 1'b1;
               end else begin
                  bus.frame_err <= 1'b1;
               end
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed table, corner sequences, and random
// line streams checked against a frame-scanning reference model.
module tb_serial_frame_rx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_frame_rx_if #(.DATA_W(8)) b0 ();
   serial_frame_rx_if #(.DATA_W(8)) b1 ();

   serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   typedef struct {
      bit         sel;
      logic [7:0] data;
      bit         par;
      bit         stop;
      bit         exp_v;
      bit         exp_e;
      logic [7:0] exp_d;
   } vec_t;

   localparam int N = 300;

   int         vecs = 0;
   int         errs = 0;
   bit         fq[$];
   bit         stim [N];
   logic [10:0] expo [N];
   vec_t       tv [10];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h want=%h", nm, got, exp);
      end
   endtask

   // {valid, frame_err, busy, data_out}
   function automatic logic [10:0] obs(input bit sel);
      if (sel) return {b1.valid, b1.frame_err, b1.busy, b1.data_out};
      return {b0.valid, b0.frame_err, b0.busy, b0.data_out};
   endfunction

   task automatic tick(input bit i0, input bit i1);
      @(negedge clk);
      b0.in = i0;
      b1.in = i1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int c = 0; c < cycles; c++) tick(1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   function automatic void push_frame(input bit sel, input logic [7:0] d, input bit par, input bit stop);
      fq.push_back(1'b1);
      for (int j = 0; j < 8; j++) fq.push_back(d[j]);
      if (sel) fq.push_back(par);
      fq.push_back(stop);
   endfunction

   task automatic play(input bit sel);
      bit x;
      while (fq.size() > 0) begin
         x = fq.pop_front();
         tick(!sel && x, sel && x);
      end
   endtask

   // Scan the whole stream frame by frame: output state after edge k.
   function automatic void build_expect(input bit sel);
      int   L = sel ? 10 : 9;
      int   i = 0;
      logic [7:0] w;
      logic [7:0] held = 8'h00;
      bit   v [N];
      bit   e [N];
      bit   b [N];
      logic [7:0] wd [N];
      bit   ok;
      for (int k = 0; k < N; k++) begin v[k] = 0; e[k] = 0; b[k] = 0; wd[k] = 0; end
      while (i < N) begin
         if (stim[i]) begin
            for (int k = i; k < i + L && k < N; k++) b[k] = 1;
            if (i + L < N) begin
               for (int j = 0; j < 8; j++) w[j] = stim[i + 1 + j];
               ok = (stim[i + L] == 1'b0);
               if (sel && (((^w) ^ stim[i + 9]) != 1'b0)) ok = 1'b0;
               if (ok) begin v[i + L] = 1; wd[i + L] = w; end
               else e[i + L] = 1;
            end
            i += L + 1;
         end else begin
            i++;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (v[k]) held = wd[k];
         expo[k] = {v[k], e[k], b[k], held};
      end
   endfunction

   initial begin
      logic [10:0] o;
      int          pulses;
      b0.in = 1'b0;
      b1.in = 1'b0;

      tv[0] = '{0, 8'h00, 0, 0, 1, 0, 8'h00};
      tv[1] = '{0, 8'hA5, 0, 0, 1, 0, 8'hA5};
      tv[2] = '{0, 8'hA5, 0, 1, 0, 1, 8'hA5};
      tv[3] = '{0, 8'hFF, 0, 0, 1, 0, 8'hFF};
      tv[4] = '{0, 8'h3C, 0, 1, 0, 1, 8'hFF};
      tv[5] = '{1, 8'hA5, 0, 0, 1, 0, 8'hA5};
      tv[6] = '{1, 8'hA5, 1, 0, 0, 1, 8'hA5};
      tv[7] = '{1, 8'h01, 1, 0, 1, 0, 8'h01};
      tv[8] = '{1, 8'h01, 0, 0, 0, 1, 8'h01};
      tv[9] = '{1, 8'h07, 1, 1, 0, 1, 8'h01};

      // reset state and quiet idle line
      do_reset(2);
      chk("reset_p0", obs(0), 11'h000);
      chk("reset_p1", obs(1), 11'h000);
      for (int c = 0; c < 20; c++) begin
         tick(1'b0, 1'b0);
         chk($sformatf("idle%0d", c), {obs(0), obs(1)}, 22'h0);
      end

      // lone start bit then zeros: single valid pulse after the stop edge
      fq.push_back(1'b1);
      for (int c = 0; c < 10; c++) fq.push_back(1'b0);
      for (int k = 0; k <= 10; k++) begin
         tick(fq[k], 1'b0);
         o = obs(0);
         chk($sformatf("lat_e%0d", k), {o[10:9], o[7:0]}, {(k == 9), 1'b0, 8'h00});
      end
      fq.delete();

      // directed table
      foreach (tv[n]) begin
         push_frame(tv[n].sel, tv[n].data, tv[n].par, tv[n].stop);
         play(tv[n].sel);
         chk($sformatf("vec%0d", n), obs(tv[n].sel), {tv[n].exp_v, tv[n].exp_e, 1'b0, tv[n].exp_d});
         tick(1'b0, 1'b0);
         o = obs(tv[n].sel);
         chk($sformatf("vec%0d_next", n), {o[10:9], o[7:0]}, {2'b00, tv[n].exp_d});
      end

      // reset mid-frame discards the partial word, then a full frame lands
      fq.push_back(1'b1);
      for (int j = 0; j < 4; j++) fq.push_back(j[0] ? 1'b0 : 1'b1);
      play(0);
      do_reset(1);
      chk("abort_reset", obs(0), 11'h000);
      pulses = 0;
      push_frame(0, 8'h3C, 0, 0);
      while (fq.size() > 0) begin
         tick(fq.pop_front(), 1'b0);
         o = obs(0);
         if (o[10] || o[9]) pulses++;
      end
      chk("abort_frame", obs(0), {1'b1, 1'b0, 1'b0, 8'h3C});
      tick(1'b0, 1'b0);
      o = obs(0);
      chk("abort_pulses", pulses + o[10] + o[9], 1);

      // back-to-back frames: start of frame 2 right after frame 1 stop edge
      push_frame(0, 8'h12, 0, 0);
      push_frame(0, 8'h34, 0, 0);
      for (int k = 0; k < 23; k++) begin
         tick((k < 20) ? fq[k] : 1'b0, 1'b0);
         o = obs(0);
         chk($sformatf("b2b_v%0d", k), {o[10:9]}, {(k == 9 || k == 19), 1'b0});
         if (k == 9)  chk("b2b_d1", o[7:0], 8'h12);
         if (k == 19) chk("b2b_d2", o[7:0], 8'h34);
      end
      fq.delete();

      // random streams against the frame-scanning model
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < N; k++) stim[k] = ($urandom_range(0, 2) == 0);
         build_expect(s[0]);
         do_reset(2);
         for (int k = 0; k < N; k++) begin
            tick(!s[0] && stim[k], s[0] && stim[k]);
            chk($sformatf("rnd%0d_%0d", s, k), obs(s[0]), expo[k]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
